icache_direct: RTL and testbench

- Direct-mapped, one-word-per-frame instruction cache between the pipeline's instruction fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller's instruction port.
- Returns hits combinationally in the request cycle.
- On a miss, fetches the word from memory, fills the frame, then serves the hit.
- Supports a whole-cache invalidate for halt/flush.

---
 rtl/icache_direct.sv | 138 +++++++++++++
 tb/tb_icache_direct.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache with a zero-latency hit path.
// Optional hit/miss statistics counters are enabled with the ICACHE_STATS_EN macro.
module icache_direct #(
  parameter int NSETS    = 16,
  parameter int PC_ALIGN = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
`ifdef ICACHE_STATS_EN
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`else
  input  logic [31:0] iload
`endif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - IDX_W - PC_ALIGN;
  localparam int WRD_W = 32 - PC_ALIGN;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NSETS-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [NSETS];
  logic [31:0]          r_data [NSETS];
  logic [WRD_W-1:0]     r_miss_word;
  logic                 r_flushed;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_miss_idx;
  logic [TAG_W-1:0]     w_miss_tag;
  logic                 w_lookup;
  logic                 w_miss;
  logic                 w_fill;
  logic                 w_unused_bits;

  assign w_idx         = imemaddr[IDX_W+PC_ALIGN-1:PC_ALIGN];
  assign w_tag         = imemaddr[31:IDX_W+PC_ALIGN];
  assign w_miss_idx    = r_miss_word[IDX_W-1:0];
  assign w_miss_tag    = r_miss_word[WRD_W-1:IDX_W];
  assign w_lookup      = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_unused_bits = ^imemaddr[PC_ALIGN-1:0];

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    w_miss   = 1'b0;
    w_fill   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_lookup) begin
          ihit     = 1'b1;
          imemload = r_data[w_idx];
        end else if (imemREN) begin
          w_miss = 1'b1;
          w_next = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {r_miss_word, {PC_ALIGN{1'b0}}};
        if (!iwait) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A flush seen while a fill is in flight leaves that frame invalid when it lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid     <= '0;
      r_miss_word <= '0;
      r_flushed   <= 1'b0;
    end else begin
      if (w_miss) begin
        r_miss_word <= imemaddr[31:PC_ALIGN];
        r_flushed   <= 1'b0;
      end else if ((r_state == FETCH) && iflush) begin
        r_flushed <= 1'b1;
      end
      if (iflush)                      r_valid             <= '0;
      else if (w_fill && !r_flushed)   r_valid[w_miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill && !RST) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (ihit)   r_hit_count  <= sat_inc(r_hit_count);
      if (w_miss) r_miss_count <= sat_inc(r_miss_count);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural cache model.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  icache_direct #(.NSETS(16), .PC_ALIGN(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iflush(iflush),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
`ifdef ICACHE_STATS_EN
    .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
`else
    .iload(iload)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: each frame remembers which word address it holds.
  bit          m_valid [16];
  logic [31:0] m_line  [16];
  logic [31:0] m_data  [16];
  bit          m_fetch = 1'b0;
  bit          m_fl    = 1'b0;
  logic [31:0] m_miss  = 32'h0;
  int unsigned m_hits  = 0;
  int unsigned m_misses = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit model_hit();
    int i;
    i = idx_of(imemaddr);
    return !m_fetch && imemREN && m_valid[i] && (m_line[i] == {imemaddr[31:2], 2'b00});
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      m_fetch = 1'b0; m_fl = 1'b0; m_miss = 32'h0;
      m_hits = 0; m_misses = 0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (!m_fetch) begin
      bit h;
      h = model_hit();
      if (h) m_hits++;
      if (iflush) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      if (imemREN && !h) begin
        m_fetch = 1'b1; m_fl = 1'b0; m_miss = {imemaddr[31:2], 2'b00}; m_misses++;
      end
    end else begin
      if (iflush) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_fl = 1'b1;
      end
      if (!iwait) begin
        m_line[idx_of(m_miss)]  = m_miss;
        m_data[idx_of(m_miss)]  = iload;
        m_valid[idx_of(m_miss)] = !m_fl;
        m_fetch = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      bit h;
      h = model_hit();
      chk("ihit", {31'b0, ihit}, {31'b0, h});
      chk("imemload", imemload, h ? m_data[idx_of(imemaddr)] : 32'h0);
      chk("iREN", {31'b0, iREN}, {31'b0, m_fetch});
      chk("iaddr", iaddr, m_fetch ? m_miss : 32'h0);
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Request one address until it hits; waits nwait FETCH cycles, optional flush pulse.
  task automatic fetch(input logic [31:0] a, input int nwait, input int flush_at,
                       output int nren, output bit first_hit, output logic [31:0] data,
                       output logic [31:0] raddr);
    int k;
    nren = 0; first_hit = 1'b0; data = 32'h0; raddr = 32'h0;
    imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iflush = 1'b0;
    @(negedge CLK);
    if (ihit) begin
      first_hit = 1'b1; data = imemload;
    end else begin
      k = 0;
      while (!ihit && k < 200) begin
        step();
        iwait  = (k < nwait);
        iflush = (k == flush_at);
        iload  = memfn({a[31:2], 2'b00});
        @(negedge CLK);
        if (iREN) begin
          if (nren == 0) raddr = iaddr;
          nren++;
        end
        if (ihit) data = imemload;
        k++;
      end
      if (k >= 200) begin
        bad++; total++;
        $display("FAIL fetch_timeout addr=%h actual=no_hit required=hit", a);
      end
    end
    step();
    imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1;
  endtask

  int          nren;
  bit          fh;
  logic [31:0] dat, ra;
  int          misses_seen;

  initial begin
    step(); step();
    RST = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'b0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    step();

    fetch(32'h40, 3, -1, nren, fh, dat, ra);
    chk("cold_first_hit", {31'b0, fh}, 32'h0);
    chk("cold_iren_cycles", nren, 4);
    chk("cold_iaddr", ra, 32'h40);
    chk("cold_data", dat, 32'h8C22_0004);

    fetch(32'h40, 0, -1, nren, fh, dat, ra);
    chk("repeat_hit", {31'b0, fh}, 32'h1);
    chk("repeat_no_iren", nren, 0);
    chk("repeat_data", dat, 32'h8C22_0004);

    misses_seen = 0;
    fetch(32'h80, 1, -1, nren, fh, dat, ra);
    if (!fh) misses_seen++;
    fetch(32'h40, 2, -1, nren, fh, dat, ra);
    if (!fh) misses_seen++;
    chk("evict_reissue_iaddr", ra, 32'h40);
    chk("evict_data", dat, 32'h8C22_0004);
    chk("evict_misses", misses_seen + 1, 3);

    fetch(32'h108, 0, -1, nren, fh, dat, ra);
    fetch(32'h108, 0, -1, nren, fh, dat, ra);
    chk("prime_108_hit", {31'b0, fh}, 32'h1);
    fetch(32'h104, 2, 1, nren, fh, dat, ra);
    chk("flush_refetch_cycles", nren, 4);
    chk("flush_104_data", dat, memfn(32'h104));
    fetch(32'h108, 0, -1, nren, fh, dat, ra);
    chk("flush_108_misses", {31'b0, fh}, 32'h0);
    fetch(32'h40, 0, -1, nren, fh, dat, ra);
    chk("flush_40_misses", {31'b0, fh}, 32'h0);

    imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1; iload = memfn(32'h300);
    step();
    step();
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_fetch_iren", {31'b0, iREN}, 32'h1);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_iren_drop", {31'b0, iREN}, 32'h0);
    chk("midrst_miss", {31'b0, ihit}, 32'h0);
    step();
    imemREN = 1'b0;
    fetch(32'h300, 1, -1, nren, fh, dat, ra);
    chk("midrst_refill_data", dat, memfn(32'h300));

`ifdef ICACHE_STATS_EN
    RST = 1'b1; step(); RST = 1'b0;
    fetch(32'h40, 1, -1, nren, fh, dat, ra);
    fetch(32'h44, 1, -1, nren, fh, dat, ra);
    fetch(32'h48, 1, -1, nren, fh, dat, ra);
    fetch(32'h40, 0, -1, nren, fh, dat, ra);
    fetch(32'h44, 0, -1, nren, fh, dat, ra);
    @(negedge CLK);
    chk("stats_miss", miss_count, 32'd3);
    chk("stats_hit", hit_count, 32'd5);
`endif

    for (int c = 0; c < 3000; c++) begin
      step();
      RST      = ($urandom_range(0, 149) == 0);
      imemREN  = ($urandom_range(0, 4) != 0);
      imemaddr = ({31'b0, 1'($urandom_range(0, 1))} << 31) |
                 (32'($urandom_range(0, 3)) << 6) |
                 (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      iwait    = ($urandom_range(0, 1) == 1);
      iflush   = ($urandom_range(0, 29) == 0);
      iload    = memfn(m_miss);
    end
    step();
    RST = 1'b0; imemREN = 1'b0; iflush = 1'b0; iwait = 1'b1;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    chk("stats_rand_hit", hit_count, m_hits);
    chk("stats_rand_miss", miss_count, m_misses);
`endif
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
